// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU and the ALU decoder.
//   aluctrl_t : 4-bit ALU operation code produced by the decoder
//   state_t   : execute-stage sequencing state (IDLE / SHIFT)
//   is_shift  : true for the sll/srl codes
package alu_pkg;

    localparam int unsigned WIDTH_DEFAULT = 32;
    localparam int unsigned SHW_DEFAULT   = 5;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_NOR = 4'b0011,
        ALU_SLL = 4'b0100,
        ALU_SRL = 4'b0101,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111
    } aluctrl_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic logic is_shift(input logic [3:0] code);
        return (code == ALU_SLL) || (code == ALU_SRL);
    endfunction

endpackage

// File: rtl/alu_exec_stage_serial_shifter.sv
// One-bit-per-cycle logical shifter used by the execute stage.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture data/amount/dir and start shifting
//   dir        : 1 = shift right (srl, zero-fill), 0 = shift left (sll)
//   data       : value to shift
//   amount     : number of single-bit shifts to perform
//   busy       : shift count not yet exhausted
//   done       : the current cycle performs the last shift
//   value      : accumulator after this cycle's shift (final result when done)
module alu_serial_shifter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned SHW   = SHW_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dir,
    input  logic [WIDTH-1:0] data,
    input  logic [SHW-1:0]   amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] value
);

    localparam logic [SHW-1:0] ONE = SHW'(1);

    logic [WIDTH-1:0] acc;
    logic [SHW-1:0]   cnt;
    logic             right;

    always_comb begin
        value = right ? {1'b0, acc[WIDTH-1:1]} : {acc[WIDTH-2:0], 1'b0};
    end

    assign busy = (cnt != '0);
    assign done = (cnt == ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            cnt   <= '0;
            right <= 1'b0;
        end else if (load) begin
            acc   <= data;
            cnt   <= amount;
            right <= dir;
        end else if (busy) begin
            acc <= value;
            cnt <= cnt - ONE;
        end
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute-stage ALU with valid/ready handshake on both sides and a registered
// result/zero output. sll/srl run serially (one bit per cycle) by default;
// defining ALU_BARREL_SHIFT_EN builds a single-cycle barrel shift instead.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operation handshake from decode/register read
//   aluctrl             : operation code (see alu_pkg::aluctrl_t)
//   srca, srcb          : operands (srcb is the shift source)
//   shamt               : shift amount
//   out_valid/out_ready : result handshake to memory/writeback
//   result, zero        : registered result and result==0 flag
module alu_exec_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT,
    parameter int unsigned SHW   = SHW_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       aluctrl,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    aluctrl_t         op;
    logic [WIDTH-1:0] alu_value;
    logic             accept;
    logic             drain;

    assign op     = aluctrl_t'(aluctrl);
    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

    // Single-cycle datapath. The shift cases also cover shamt==0 in the
    // serial build, where they reduce to passing srcb through.
    always_comb begin
        alu_value = '0;
        case (op)
            ALU_AND: alu_value = srca & srcb;
            ALU_OR:  alu_value = srca | srcb;
            ALU_ADD: alu_value = srca + srcb;
            ALU_NOR: alu_value = ~(srca | srcb);
            ALU_SLL: alu_value = srcb << shamt;
            ALU_SRL: alu_value = srcb >> shamt;
            ALU_SUB: alu_value = srca - srcb;
            ALU_SLT: alu_value = {{(WIDTH-1){1'b0}}, ($signed(srca) < $signed(srcb))};
            default: alu_value = '0;
        endcase
    end

`ifdef ALU_BARREL_SHIFT_EN

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
        end else if (accept) begin
            result    <= alu_value;
            zero      <= (alu_value == '0);
            out_valid <= 1'b1;
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

`else

    state_t           state;
    logic             start_shift;
    logic             sh_busy;
    logic             sh_done;
    logic [WIDTH-1:0] sh_value;

    // Entry into SHIFT requires the output register to be free or draining,
    // so the shift never has to stall on out_ready when it finishes.
    assign in_ready    = (state == IDLE) && !sh_busy && (!out_valid || out_ready);
    assign start_shift = accept && is_shift(aluctrl) && (shamt != '0);

    alu_serial_shifter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shifter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (start_shift),
        .dir    (op == ALU_SRL),
        .data   (srcb),
        .amount (shamt),
        .busy   (sh_busy),
        .done   (sh_done),
        .value  (sh_value)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start_shift) begin
                        state     <= SHIFT;
                        out_valid <= 1'b0;
                    end else if (accept) begin
                        result    <= alu_value;
                        zero      <= (alu_value == '0);
                        out_valid <= 1'b1;
                    end else if (drain) begin
                        out_valid <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (sh_done) begin
                        result    <= sh_value;
                        zero      <= (sh_value == '0);
                        out_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
module tb_alu_exec_stage;
    import alu_pkg::*;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   aluctrl = 4'h0;
    logic [W-1:0] srca = '0;
    logic [W-1:0] srcb = '0;
    logic [4:0]   shamt = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         zero;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_exec_stage #(.WIDTH(W), .SHW(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluctrl   (aluctrl),
        .srca      (srca),
        .srcb      (srcb),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    // Present one operation for exactly one clock edge; returns 1ns after it.
    task automatic send(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] sh);
        @(negedge clk);
        aluctrl = op; srca = a; srcb = b; shamt = sh; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 00000000", result); end
        total++; if (zero !== 1'b1) begin bad++; $display("FAIL reset_zero: got %b want 1", zero); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        send(ALU_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_valid: got %b want 1", out_valid); end
        total++; if (result !== 32'h8000_0000) begin bad++; $display("FAIL add_result: got %h want 80000000", result); end
        total++; if (zero !== 1'b0) begin bad++; $display("FAIL add_zero: got %b want 0", zero); end
        send(ALU_ADD, 32'hFFFF_FFFF, 32'h2, 5'd0);
        total++; if (result !== 32'h1) begin bad++; $display("FAIL add_wrap: got %h want 00000001", result); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_sub_slt();
        out_ready = 1'b1;
        @(negedge clk);
        aluctrl = ALU_SUB; srca = 32'd5; srcb = 32'd5; shamt = '0; in_valid = 1'b1;
        @(posedge clk); #1;
        total++; if (result !== 32'h0) begin bad++; $display("FAIL sub_result: got %h want 00000000", result); end
        total++; if (zero !== 1'b1) begin bad++; $display("FAIL sub_zero: got %b want 1", zero); end
        aluctrl = ALU_SLT; srca = 32'hFFFF_FFFF; srcb = 32'h1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL slt_valid: got %b want 1", out_valid); end
        total++; if (result !== 32'h1) begin bad++; $display("FAIL slt_result: got %h want 00000001", result); end
        total++; if (zero !== 1'b0) begin bad++; $display("FAIL slt_zero: got %b want 0", zero); end
        @(posedge clk); #1;
    endtask

    task automatic test_sll31();
        int low;
        int expected_low;
`ifdef ALU_BARREL_SHIFT_EN
        expected_low = 0;
`else
        expected_low = 31;
`endif
        out_ready = 1'b1;
        send(ALU_SLL, 32'h0, 32'h1, 5'd31);
        low = 0;
        while (!out_valid && low < 100) begin
            if (!in_ready) low++;
            @(posedge clk); #1;
        end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sll31_valid: got %b want 1", out_valid); end
        total++; if (low != expected_low) begin bad++; $display("FAIL sll31_busy_cycles: got %0d want %0d", low, expected_low); end
        total++; if (result !== 32'h8000_0000) begin bad++; $display("FAIL sll31_result: got %h want 80000000", result); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_pressure();
        int held_bad;
        out_ready = 1'b0;
        @(negedge clk);
        aluctrl = ALU_OR; srca = 32'hF0; srcb = 32'h0F; shamt = '0; in_valid = 1'b1;
        @(posedge clk); #1;
        aluctrl = ALU_AND; srca = 32'hFF; srcb = 32'h0F;
        total++; if (result !== 32'hFF) begin bad++; $display("FAIL bp_first: got %h want 000000ff", result); end
        held_bad = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (result !== 32'hFF || out_valid !== 1'b1 || in_ready !== 1'b0) held_bad++;
        end
        total++; if (held_bad != 0) begin bad++; $display("FAIL bp_hold: got %0d bad cycles want 0", held_bad); end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_on_drain: got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_second_valid: got %b want 1", out_valid); end
        total++; if (result !== 32'h0F) begin bad++; $display("FAIL bp_second: got %h want 0000000f", result); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain: got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid_shift();
        int seen;
        out_ready = 1'b1;
        send(ALU_SRL, 32'h0, 32'hFFFF_FFFF, 5'd20);
        repeat (6) @(posedge clk);
        #1;
`ifndef ALU_BARREL_SHIFT_EN
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_mid_busy: got %b want 0", in_ready); end
`endif
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL rst_mid_result: got %h want 00000000", result); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_idle: got %b want 1", in_ready); end
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL rst_mid_no_result: got %0d valid cycles want 0", seen); end
    endtask

    task automatic test_undef_and_shamt0();
        int cyc;
        int expected_cyc;
`ifdef ALU_BARREL_SHIFT_EN
        expected_cyc = 1;
`else
        expected_cyc = 5;
`endif
        out_ready = 1'b1;
        send(ALU_OR, 32'h1, 32'h2, 5'd0);
        total++; if (result !== 32'h3) begin bad++; $display("FAIL or_result: got %h want 00000003", result); end
        send(4'b1010, 32'h1, 32'h1, 5'd0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL undef_valid: got %b want 1", out_valid); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL undef_result: got %h want 00000000", result); end
        total++; if (zero !== 1'b1) begin bad++; $display("FAIL undef_zero: got %b want 1", zero); end
        send(ALU_SRL, 32'h0, 32'hA5, 5'd0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL srl0_valid: got %b want 1", out_valid); end
        total++; if (result !== 32'hA5) begin bad++; $display("FAIL srl0_result: got %h want 000000a5", result); end
        send(ALU_NOR, 32'h0F0F_0F0F, 32'hF0F0_F000, 5'd0);
        total++; if (result !== 32'h0000_00F0) begin bad++; $display("FAIL nor_result: got %h want 000000f0", result); end
        send(ALU_SRL, 32'h0, 32'h8000_0000, 5'd4);
        cyc = 1;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        total++; if (cyc != expected_cyc) begin bad++; $display("FAIL srl4_latency: got %0d want %0d", cyc, expected_cyc); end
        total++; if (result !== 32'h0800_0000) begin bad++; $display("FAIL srl4_result: got %h want 08000000", result); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_slt();
        test_sll31();
        test_back_pressure();
        test_reset_mid_shift();
        test_undef_and_shamt0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
